// File: rtl/cmos_window_capture.sv
// rtl/cmos_window_capture.sv - CMOS sensor window crop, decimation, armed capture and geometry measurement
module cmos_window_capture #(
  parameter int DATA_SIZE = 10,
  parameter int CNT_W     = 16,
  parameter int FRAME_W   = 32
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [DATA_SIZE-1:0] iDATA,
  input  logic                 iFVAL,
  input  logic                 iLVAL,
  input  logic                 iSTART,
  input  logic                 iEND,
  input  logic [1:0]           iMODE,
  input  logic [7:0]           iNUM_FRAMES,
  input  logic [CNT_W-1:0]     iX_POS,
  input  logic [CNT_W-1:0]     iY_POS,
  input  logic [CNT_W-1:0]     iWIDTH,
  input  logic [CNT_W-1:0]     iHEIGHT,
  input  logic [1:0]           iDECIM,
  output logic [DATA_SIZE-1:0] oDATA,
  output logic                 oDVAL,
  output logic                 oSOF,
  output logic                 oEOF,
  output logic [CNT_W-1:0]     oX_Cont,
  output logic [CNT_W-1:0]     oY_Cont,
  output logic [CNT_W-1:0]     oTX_Cont,
  output logic [CNT_W-1:0]     oTY_Cont,
  output logic                 oGEO_VAL,
  output logic [FRAME_W-1:0]   oFrame_Cont,
  output logic                 oBUSY
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t               state;
  logic [DATA_SIZE-1:0] rD;
  logic                 rF, rL, rF_d, run_d;
  logic [CNT_W-1:0]     x_cnt, y_cnt, max_len;
  logic                 y_started, stop_pend, sof_seen;
  logic [7:0]           frames_left;
  logic [1:0]           lmode, ldecim;
  logic [CNT_W-1:0]     lx0, ly0, lw, lh;

  logic                 run, f_rise, f_fall, l_rise, entering, cap_now, dval;
  logic [CNT_W-1:0]     x_cur, y_cur, line_len, ty_val;
  logic [CNT_W-1:0]     wx0, wy0, ww, wh;
  logic [1:0]           wdec;
  logic [CNT_W:0]       x_lo, x_hi, y_lo, y_hi, dx, dy;
  logic [2:0]           mask;
  logic                 in_x, in_y, dec_ok;

  assign run    = rF & rL;
  assign f_rise = rF & ~rF_d;
  assign f_fall = ~rF & rF_d;
  assign l_rise = run & ~run_d;

  // Pixel/line index of the pixel currently held in stage 1
  always_comb begin
    x_cur = '0;
    if (run) x_cur = run_d ? sat_inc(x_cnt) : '0;
    y_cur = '0;
    if (rF) begin
      if (l_rise) y_cur = y_started ? sat_inc(y_cnt) : '0;
      else        y_cur = y_cnt;
    end
    line_len = sat_inc(x_cur);
    ty_val   = y_started ? sat_inc(y_cnt) : '0;
  end

  // Window test; on the entry cycle the live configuration is used since it is being latched
  always_comb begin
    entering = (state == ARMED) & f_rise & ~iEND;
    cap_now  = (state == CAPTURE) | entering;
    wx0  = entering ? iX_POS  : lx0;
    wy0  = entering ? iY_POS  : ly0;
    ww   = entering ? iWIDTH  : lw;
    wh   = entering ? iHEIGHT : lh;
    wdec = entering ? iDECIM  : ldecim;
    x_lo = {1'b0, wx0};
    y_lo = {1'b0, wy0};
    x_hi = x_lo + {1'b0, ww};
    y_hi = y_lo + {1'b0, wh};
    dx   = {1'b0, x_cur} - x_lo;
    dy   = {1'b0, y_cur} - y_lo;
    in_x = ({1'b0, x_cur} >= x_lo) && ({1'b0, x_cur} < x_hi);
    in_y = ({1'b0, y_cur} >= y_lo) && ({1'b0, y_cur} < y_hi);
    case (wdec)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    dec_ok = ((dx[2:0] & mask) == 3'b000) && ((dy[2:0] & mask) == 3'b000);
    dval   = cap_now & run & in_x & in_y & dec_ok;
  end

  // Stage 1: register sensor pins and keep previous sync values for edge detection
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rD <= '0; rF <= 1'b0; rL <= 1'b0; rF_d <= 1'b0; run_d <= 1'b0;
    end else begin
      rD <= iDATA; rF <= iFVAL; rL <= iLVAL; rF_d <= rF; run_d <= run;
    end
  end

  // Free-running counters, geometry measurement and frame count
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_cnt <= '0; y_cnt <= '0; y_started <= 1'b0; max_len <= '0;
      oX_Cont <= '0; oY_Cont <= '0; oTX_Cont <= '0; oTY_Cont <= '0;
      oGEO_VAL <= 1'b0; oFrame_Cont <= '0;
    end else begin
      x_cnt     <= x_cur;
      y_cnt     <= y_cur;
      y_started <= rF & (y_started | l_rise);
      oX_Cont   <= x_cur;
      oY_Cont   <= y_cur;
      oGEO_VAL  <= f_fall;
      if (f_fall) begin
        oTX_Cont <= max_len;
        oTY_Cont <= ty_val;
      end
      if (!rF) max_len <= '0;
      else if (run && line_len > max_len) max_len <= line_len;
      if (f_rise) oFrame_Cont <= oFrame_Cont + 1'b1;
    end
  end

  // Output pixel stage: data holds when not valid, SOF marks first valid pixel of a frame
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDATA <= '0; oDVAL <= 1'b0; oSOF <= 1'b0; sof_seen <= 1'b0;
    end else begin
      oDVAL <= dval;
      oSOF  <= dval & (entering | ~sof_seen);
      if (dval) oDATA <= rD;
      if (entering)  sof_seen <= dval;
      else if (dval) sof_seen <= 1'b1;
    end
  end

  // Capture control FSM: arm, whole-frame capture, mode-dependent re-arm, deferred stop
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE; oBUSY <= 1'b0; oEOF <= 1'b0; stop_pend <= 1'b0;
      frames_left <= '0; lmode <= '0; ldecim <= '0;
      lx0 <= '0; ly0 <= '0; lw <= '0; lh <= '0;
    end else begin
      oEOF <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART && !iEND) begin
            state       <= ARMED;
            oBUSY       <= 1'b1;
            lmode       <= iMODE;
            frames_left <= (iNUM_FRAMES == 8'd0) ? 8'd1 : iNUM_FRAMES;
          end
        end
        ARMED: begin
          if (iEND) begin
            state <= IDLE;
            oBUSY <= 1'b0;
          end else if (f_rise) begin
            state     <= CAPTURE;
            stop_pend <= 1'b0;
            lx0 <= iX_POS; ly0 <= iY_POS; lw <= iWIDTH; lh <= iHEIGHT; ldecim <= iDECIM;
          end
        end
        CAPTURE: begin
          if (f_fall) begin
            oEOF      <= 1'b1;
            stop_pend <= 1'b0;
            if (stop_pend || iEND || lmode == 2'd1 || lmode == 2'd3 ||
                (lmode == 2'd2 && frames_left <= 8'd1)) begin
              state <= IDLE;
              oBUSY <= 1'b0;
            end else begin
              state <= ARMED;
              if (lmode == 2'd2) frames_left <= frames_left - 8'd1;
            end
          end else if (iEND) begin
            stop_pend <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
